// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter for a single memory port: round-robin grant,
// one outstanding transaction, bus timeout with error response.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_q, state_d;
  logic                last_lsu_q, last_lsu_d;
  logic                owner_q, owner_d;   // 1 = LSU owns the transaction
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]       wmask_q, wmask_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ifu_rv_q, ifu_rv_d, ifu_err_q, ifu_err_d;
  logic                lsu_rv_q, lsu_rv_d, lsu_err_q, lsu_err_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

  logic                gnt_ifu, gnt_lsu, timeout_hit;
  logic                done, done_err;
  logic [DATA_W-1:0]   done_data;

  // On a tie the master that was not granted last wins.
  assign gnt_ifu     = (state_q == IDLE) && ifu_req_valid && (!lsu_req_valid || last_lsu_q);
  assign gnt_lsu     = (state_q == IDLE) && lsu_req_valid && !gnt_ifu;
  assign timeout_hit = (state_q != IDLE) && (cnt_q == TO_LAST);

  assign ifu_req_ready  = rst_n && gnt_ifu;
  assign lsu_req_ready  = rst_n && gnt_lsu;
  assign mem_req_valid  = (state_q == ISSUE) && !timeout_hit;
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign busy           = (state_q != IDLE);
  assign ifu_resp_valid = ifu_rv_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign ifu_resp_err   = ifu_err_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign lsu_resp_err   = lsu_err_q;

  always_comb begin
    state_d     = state_q;
    last_lsu_d  = last_lsu_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    ifu_rv_d    = 1'b0;
    lsu_rv_d    = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    ifu_err_d   = ifu_err_q;
    lsu_rdata_d = lsu_rdata_q;
    lsu_err_d   = lsu_err_q;
    done        = 1'b0;
    done_err    = 1'b0;
    done_data   = '0;

    case (state_q)
      IDLE: begin
        if (gnt_ifu || gnt_lsu) begin
          owner_d    = gnt_lsu;
          last_lsu_d = gnt_lsu;
          addr_d     = gnt_lsu ? lsu_addr : ifu_addr;
          wen_d      = gnt_lsu && lsu_wen;
          wdata_d    = gnt_lsu ? lsu_wdata : '0;
          wmask_d    = gnt_lsu ? lsu_wmask : '0;
          cnt_d      = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving in the timeout cycle still counts as success.
        if (mem_resp_valid) begin
          done      = 1'b1;
          done_data = (owner_q && wen_q) ? '0 : mem_rdata;
        end else if (timeout_hit) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d = IDLE;
      if (owner_q) begin
        lsu_rv_d    = 1'b1;
        lsu_rdata_d = done_data;
        lsu_err_d   = done_err;
      end else begin
        ifu_rv_d    = 1'b1;
        ifu_rdata_d = done_data;
        ifu_err_d   = done_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_lsu_q  <= 1'b1;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      ifu_rv_q    <= 1'b0;
      ifu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      lsu_rv_q    <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_lsu_q  <= last_lsu_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      ifu_rv_q    <= ifu_rv_d;
      ifu_rdata_q <= ifu_rdata_d;
      ifu_err_q   <= ifu_err_d;
      lsu_rv_q    <= lsu_rv_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_err_q   <= lsu_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one in-flight record, its age in cycles
  // since acceptance, and whether memory has taken the request yet.
  bit            m_busy, m_own, m_hand, m_last_ifu, m_pend, m_pown;
  int            m_age;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_wen;
  logic [MW-1:0] m_wmask;
  logic [DW-1:0] m_rd [2];
  bit            m_er [2];
  bit            w_ifu, w_lsu, exp_mreq;

  task automatic m_finish(input bit err, input logic [DW-1:0] d);
    m_busy      = 1'b0;
    m_pend      = 1'b1;
    m_pown      = m_own;
    m_rd[m_own] = d;
    m_er[m_own] = err;
  endtask

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_hand = 0; m_age = 0; m_last_ifu = 0; m_pend = 0;
        m_rd[0] = '0; m_rd[1] = '0; m_er[0] = 0; m_er[1] = 0;
      end else begin
        w_ifu    = !m_busy && ifu_req_valid && (!lsu_req_valid || !m_last_ifu);
        w_lsu    = !m_busy && lsu_req_valid && !w_ifu;
        exp_mreq = m_busy && !m_hand && (m_age != TO);
        chk("ifu_req_ready", ifu_req_ready, w_ifu);
        chk("lsu_req_ready", lsu_req_ready, w_lsu);
        chk("busy", busy, m_busy);
        chk("mem_req_valid", mem_req_valid, exp_mreq);
        if (exp_mreq) begin
          chk("mem_addr", mem_addr, m_addr);
          chk("mem_wen", mem_wen, m_wen);
          chk("mem_wmask", mem_wmask, m_wmask);
          if (m_own) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("ifu_resp_valid", ifu_resp_valid, m_pend && !m_pown);
        chk("lsu_resp_valid", lsu_resp_valid, m_pend && m_pown);
        chk("ifu_rdata", ifu_rdata, m_rd[0]);
        chk("ifu_resp_err", ifu_resp_err, m_er[0]);
        chk("lsu_rdata", lsu_rdata, m_rd[1]);
        chk("lsu_resp_err", lsu_resp_err, m_er[1]);

        m_pend = 0;
        if (m_busy) begin
          if (m_hand && mem_resp_valid) m_finish(1'b0, (m_own && m_wen) ? '0 : mem_rdata);
          else if (m_age == TO) m_finish(1'b1, '0);
          else begin
            if (exp_mreq && mem_req_ready) m_hand = 1;
            m_age++;
          end
        end else if (w_ifu || w_lsu) begin
          m_busy     = 1;
          m_own      = w_lsu;
          m_last_ifu = w_ifu;
          m_addr     = w_lsu ? lsu_addr : ifu_addr;
          m_wen      = w_lsu && lsu_wen;
          m_wdata    = w_lsu ? lsu_wdata : '0;
          m_wmask    = w_lsu ? lsu_wmask : '0;
          m_hand     = 0;
          m_age      = 1;
        end
      end
    end
  end

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int grants[$];
  int exp_order[4] = '{0, 1, 0, 1};
  bit slow;

  initial begin
    idle_inputs();
    ifu_req_valid = 1; lsu_req_valid = 1;
    #12;
    chk("rst_ifu_ready", ifu_req_ready, 0);
    chk("rst_lsu_ready", lsu_req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ifu_rdata", ifu_rdata, 0);
    idle_inputs();
    nxt();
    rst_n = 1;

    // Single IFU read, memory ready at once
    ifu_req_valid = 1; ifu_addr = 64'h1000; mem_req_ready = 1;
    smp(); chk("t1_ifu_ready", ifu_req_ready, 1); chk("t1_lsu_ready", lsu_req_ready, 0);
    nxt(); ifu_req_valid = 0;
    smp(); chk("t1_mreq", mem_req_valid, 1); chk("t1_mwen", mem_wen, 0);
    chk("t1_mwmask", mem_wmask, 0); chk("t1_maddr", mem_addr, 64'h1000);
    nxt(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h00000013_00000093;
    smp();
    nxt(); mem_resp_valid = 0; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    smp(); chk("t1_ifu_rv", ifu_resp_valid, 1); chk("t1_ifu_rdata", ifu_rdata, 64'h00000013_00000093);
    chk("t1_ifu_err", ifu_resp_err, 0); chk("t1_lsu_rv", lsu_resp_valid, 0);
    nxt();
    smp(); chk("t1_ifu_rv_pulse", ifu_resp_valid, 0);

    // LSU write with memory ready delayed 4 cycles
    nxt();
    lsu_req_valid = 1; lsu_addr = 64'h80001000; lsu_wen = 1;
    lsu_wdata = 64'hDEADBEEF; lsu_wmask = 8'h0F;
    smp(); chk("t2_lsu_ready", lsu_req_ready, 1);
    nxt(); lsu_req_valid = 0; lsu_addr = 64'h5555; lsu_wdata = 64'h1; lsu_wmask = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t2_mreq", mem_req_valid, 1); chk("t2_maddr", mem_addr, 64'h80001000);
      chk("t2_mwen", mem_wen, 1); chk("t2_mwdata", mem_wdata, 64'hDEADBEEF);
      chk("t2_mwmask", mem_wmask, 8'h0F);
      nxt();
    end
    mem_req_ready = 1;
    smp(); chk("t2_mreq_hs", mem_req_valid, 1);
    nxt(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h12345678_9ABCDEF0;
    smp(); chk("t2_busy", busy, 1);
    nxt(); mem_resp_valid = 0;
    smp(); chk("t2_lsu_rv", lsu_resp_valid, 1); chk("t2_lsu_rdata", lsu_rdata, 0);
    chk("t2_lsu_err", lsu_resp_err, 0); chk("t2_ifu_rv", ifu_resp_valid, 0);

    // Both masters continuously valid: grants must alternate
    nxt();
    ifu_req_valid = 1; ifu_addr = 64'hA0; lsu_req_valid = 1; lsu_addr = 64'hB0; lsu_wen = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 64'h77;
    for (int i = 0; i < 12; i++) begin
      smp();
      chk("t3_both_ready", ifu_req_ready & lsu_req_ready, 0);
      if (ifu_req_ready) grants.push_back(0);
      if (lsu_req_ready) grants.push_back(1);
      nxt();
    end
    idle_inputs();
    chk("t3_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t3_grant_order", (i < grants.size()) ? grants[i] : 9, exp_order[i]);

    // Memory never responds: timeout error
    ifu_req_valid = 1; ifu_addr = 64'hC0; mem_req_ready = 1;
    smp(); chk("t4_ifu_ready", ifu_req_ready, 1);
    nxt(); ifu_req_valid = 0;
    for (int k = 1; k <= TO; k++) begin
      smp(); chk("t4_no_resp_yet", ifu_resp_valid, 0);
      nxt();
    end
    smp(); chk("t4_err_rv", ifu_resp_valid, 1); chk("t4_err", ifu_resp_err, 1);
    chk("t4_err_rdata", ifu_rdata, 0); chk("t4_busy", busy, 0);
    nxt();
    smp(); chk("t4_rv_pulse", ifu_resp_valid, 0);
    nxt(); mem_resp_valid = 1; mem_rdata = 64'hBAD;
    smp(); chk("t4_late_busy", busy, 0);
    nxt(); mem_resp_valid = 0;
    smp(); chk("t4_late_ifu_rv", ifu_resp_valid, 0); chk("t4_late_lsu_rv", lsu_resp_valid, 0);
    chk("t4_err_hold", ifu_resp_err, 1);

    // Reset during WAIT
    nxt(); ifu_req_valid = 1; ifu_addr = 64'h2000; mem_req_ready = 1;
    smp();
    nxt(); ifu_req_valid = 0;
    smp();
    nxt(); mem_req_ready = 0;
    smp(); chk("t5_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_busy_rst", busy, 0); chk("t5_mreq_rst", mem_req_valid, 0);
    chk("t5_ifu_rv_rst", ifu_resp_valid, 0); chk("t5_lsu_rv_rst", lsu_resp_valid, 0);
    chk("t5_ifu_err_rst", ifu_resp_err, 0); chk("t5_maddr_rst", mem_addr, 0);
    nxt(); rst_n = 1; ifu_req_valid = 1; lsu_req_valid = 1;
    smp(); chk("t5_tie_ifu", ifu_req_ready, 1); chk("t5_tie_lsu", lsu_req_ready, 0);
    chk("t5_no_resp", ifu_resp_valid, 0);

    // Randomized traffic with fast and slow memory phases
    slow = 0;
    for (int c = 0; c < 4000; c++) begin
      nxt();
      if (c % 200 == 0) slow = $urandom_range(0, 1);
      ifu_req_valid  = $urandom_range(0, 1);
      ifu_addr       = {$urandom, $urandom};
      lsu_req_valid  = $urandom_range(0, 1);
      lsu_addr       = {$urandom, $urandom};
      lsu_wen        = $urandom_range(0, 1);
      lsu_wdata      = {$urandom, $urandom};
      lsu_wmask      = MW'($urandom);
      mem_req_ready  = slow ? ($urandom_range(0, 9) == 0) : $urandom_range(0, 1);
      mem_resp_valid = slow ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      mem_rdata      = {$urandom, $urandom};
    end
    nxt(); idle_inputs();
    smp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
